// File: rtl/alu_wb_pkg.sv
// Shared constants for the ALU writeback stage: condition codes, flag bit
// positions and the writeback state encoding.
package alu_wb_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int SAT    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HI   = 1'b1
  } wb_state_t;

endpackage

// File: rtl/alu_writeback_cond_check.sv
// ARM condition-field evaluator against the architectural NZCV flags.
// Purely combinational; NV (4'b1111) never passes.
module cond_check
  import alu_wb_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: NZCV/Q flag state, condition evaluation and register-file write port.
// Long ops (two results, serialised over two cycles) only when ALU_WB_LONG_EN is defined.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] Result,
  input  logic [DATA_W-1:0] Result2,
  input  logic [4:0]        ALUFlags,
  input  logic [3:0]        Cond,
  input  logic [1:0]        FlagW,
  input  logic              RegW,
  input  logic              Long,
  input  logic [ADDR_W-1:0] RdLo,
  input  logic [ADDR_W-1:0] RdHi,
  input  logic              QClr,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WA3,
  output logic [DATA_W-1:0] WD3,
  output logic [3:0]        Flags,
  output logic              QFlag,
  output logic              CondEx
);

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  logic [3:0]        r_flags;
  logic              r_q;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic [ADDR_W-1:0] r_hi_addr;
  logic [DATA_W-1:0] r_hi_dat;

  logic              w_cond_ex;
  logic              w_accept;
  logic              w_exec;
  logic              w_long;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_dat;
  logic              w_hi_load;

`ifdef ALU_WB_LONG_EN
  assign w_long  = Long;
  assign InReady = (r_state == ST_IDLE);
`else
  // Without long-op support the HI state is unreachable and Long is a don't-care.
  logic w_unused;
  assign w_unused = Long;
  assign w_long   = 1'b0;
  assign InReady  = 1'b1;
`endif

  cond_check u_cond_check (
    .i_cond    (Cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_accept = InValid & InReady;
  assign w_exec   = w_accept & w_cond_ex;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_addr   = RdLo;
    w_wr_dat    = Result;
    w_hi_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_exec && RegW) begin
          w_wr_en = 1'b1;
          if (w_long) begin
            w_hi_load   = 1'b1;
            w_state_nxt = ST_HI;
          end
        end
      end
      ST_HI: begin
        w_wr_en     = 1'b1;
        w_wr_addr   = r_hi_addr;
        w_wr_dat    = r_hi_dat;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_reg_write <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_hi_addr   <= '0;
      r_hi_dat    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_reg_write <= w_wr_en;
      if (w_wr_en) begin
        r_wa <= w_wr_addr;
        r_wd <= w_wr_dat;
      end
      if (w_hi_load) begin
        r_hi_addr <= RdHi;
        r_hi_dat  <= Result2;
      end
    end
  end

  // Set beats clear when a saturating op also carries QClr.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flags <= 4'b0000;
      r_q     <= 1'b0;
    end else if (w_exec) begin
      if (FlagW[1]) begin
        r_flags[FLAG_N] <= ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagW[0]) begin
        r_flags[FLAG_C] <= ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
      r_q <= ALUFlags[SAT] | (r_q & ~QClr);
    end
  end

  assign RegWrite = r_reg_write;
  assign WA3      = r_wa;
  assign WD3      = r_wd;
  assign Flags    = r_flags;
  assign QFlag    = r_q;
  assign CondEx   = w_cond_ex;

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: expected writes queued at issue, popped when RegWrite fires.
// Covers both builds (ALU_WB_LONG_EN defined or not).
module tb_alu_writeback;

`ifdef ALU_WB_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] Result;
  logic [31:0] Result2;
  logic [4:0]  ALUFlags;
  logic [3:0]  Cond;
  logic [1:0]  FlagW;
  logic        RegW;
  logic        Long;
  logic [3:0]  RdLo;
  logic [3:0]  RdHi;
  logic        QClr;
  logic        RegWrite;
  logic [3:0]  WA3;
  logic [31:0] WD3;
  logic [3:0]  Flags;
  logic        QFlag;
  logic        CondEx;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [35:0] sb[$];
  logic [35:0] sb_exp;
  logic [3:0]  m_flags;
  logic        m_q;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .Result(Result), .Result2(Result2), .ALUFlags(ALUFlags), .Cond(Cond),
    .FlagW(FlagW), .RegW(RegW), .Long(Long), .RdLo(RdLo), .RdHi(RdHi),
    .QClr(QClr), .RegWrite(RegWrite), .WA3(WA3), .WD3(WD3), .Flags(Flags),
    .QFlag(QFlag), .CondEx(CondEx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Write monitor: every RegWrite pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {WA3, WD3}, 64'd0);
      end else begin
        sb_exp = sb.pop_front();
        chk("wa3", WA3, sb_exp[35:32]);
        chk("wd3", WD3, sb_exp[31:0]);
      end
    end
  end

  // Called at a negedge; returns at a negedge with the stage idle again.
  task automatic op(input logic [3:0] cond, input logic [1:0] fw, input logic [4:0] af,
                    input logic rw, input logic lg, input logic [3:0] lo, input logic [3:0] hi,
                    input logic [31:0] r1, input logic [31:0] r2, input logic qc,
                    input logic rst_hi);
    logic cx, go_hi;
    cx = cond_pass(cond, m_flags);
    Cond = cond; FlagW = fw; ALUFlags = af; RegW = rw; Long = lg;
    RdLo = lo; RdHi = hi; Result = r1; Result2 = r2; QClr = qc; InValid = 1'b1;
    #1;
    chk("in_ready", InReady, 1);
    chk("cond_ex", CondEx, cx);
    go_hi = cx & rw & lg & LONG_EN;
    if (cx) begin
      if (fw[1]) m_flags[3:2] = af[3:2];
      if (fw[0]) m_flags[1:0] = af[1:0];
      m_q = af[4] | (m_q & ~qc);
      if (rw) sb.push_back({lo, r1});
      if (go_hi && !rst_hi) sb.push_back({hi, r2});
    end
    @(negedge clk);
    InValid = 1'b0; QClr = 1'b0;
    chk("flags", Flags, m_flags);
    chk("qflag", QFlag, m_q);
    chk("ready_hi", InReady, !go_hi);
    if (go_hi) begin
      if (rst_hi) begin
        reset = 1'b0; m_flags = 4'b0000; m_q = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1;
      chk("ready_back", InReady, 1);
      if (rst_hi) begin
        chk("rst_hi_regwrite", RegWrite, 0);
        chk("rst_hi_wa3", WA3, 0);
        chk("rst_hi_wd3", WD3, 0);
        chk("rst_hi_flags", Flags, 0);
        chk("rst_hi_q", QFlag, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] c;
    logic       qc;
    reset = 1'b0; InValid = 1'b0; Result = '0; Result2 = '0; ALUFlags = '0;
    Cond = 4'he; FlagW = '0; RegW = 1'b0; Long = 1'b0; RdLo = '0; RdHi = '0; QClr = 1'b0;
    m_flags = 4'b0000; m_q = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_regwrite", RegWrite, 0);
    chk("reset_wa3", WA3, 0);
    chk("reset_wd3", WD3, 0);
    chk("reset_flags", Flags, 0);
    chk("reset_q", QFlag, 0);
    chk("reset_ready", InReady, 1);
    reset = 1'b1;
    @(negedge clk);

    // SUBS producing Z and C, then EQ must pass on the new flags.
    op(4'he, 2'b11, 5'b00110, 1, 0, 4'd3, 4'd0, 32'h0, 32'h0, 0, 0);
    chk("subs_flags", Flags, 4'b0110);
    op(4'h0, 2'b00, 5'b00000, 1, 0, 4'd7, 4'd0, 32'h55, 32'h0, 0, 0);

    // Clear flags, then a failing EQ must not write or update anything.
    op(4'he, 2'b11, 5'b00000, 0, 0, 4'd1, 4'd0, 32'h1, 32'h0, 0, 0);
    op(4'h0, 2'b11, 5'b01111, 1, 0, 4'd9, 4'd0, 32'hDEAD, 32'h0, 0, 0);
    chk("eq_fail_flags", Flags, 4'b0000);
    chk("hold_wa3", WA3, 4'd7);
    chk("hold_wd3", WD3, 32'h55);

    // Long op: low word then high word, InReady low only in HI.
    op(4'he, 2'b00, 5'b00000, 1, 1, 4'd4, 4'd5, 32'h89ABCDEF, 32'h01234567, 0, 0);
    // Same destination for both halves: high word is final.
    op(4'he, 2'b00, 5'b00000, 1, 1, 4'd6, 4'd6, 32'hAAAA0000, 32'h0000BBBB, 0, 0);
    @(negedge clk);
    chk("same_rd_final", WD3, LONG_EN ? 32'h0000BBBB : 32'hAAAA0000);
    // Long without RegW: flags only.
    op(4'he, 2'b11, 5'b01001, 0, 1, 4'd2, 4'd8, 32'h1, 32'h2, 0, 0);

    // Sticky Q: set, hold, clear, set-beats-clear.
    op(4'he, 2'b00, 5'b10000, 0, 0, 4'd0, 4'd0, 32'h0, 32'h0, 0, 0);
    op(4'he, 2'b00, 5'b00000, 1, 0, 4'd1, 4'd0, 32'h11, 32'h0, 0, 0);
    chk("q_sticky", QFlag, 1);
    op(4'he, 2'b00, 5'b00000, 0, 0, 4'd0, 4'd0, 32'h0, 32'h0, 1, 0);
    chk("q_cleared", QFlag, 0);
    op(4'he, 2'b00, 5'b10000, 0, 0, 4'd0, 4'd0, 32'h0, 32'h0, 1, 0);
    chk("q_set_wins", QFlag, 1);

    // NV never executes.
    op(4'hf, 2'b11, 5'b11111, 1, 0, 4'd2, 4'd0, 32'hBAD, 32'h0, 0, 0);

    // Randomised ops; QClr only on executing ops.
    for (int i = 0; i < 48; i++) begin
      c  = 4'($urandom_range(0, 15));
      qc = cond_pass(c, m_flags) ? 1'($urandom_range(0, 1)) : 1'b0;
      op(c, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
         $urandom, $urandom, qc, 0);
    end

    // Reset during HI drops the high-word write.
    op(4'he, 2'b11, 5'b11111, 1, 1, 4'd10, 4'd11, 32'h12345678, 32'h9ABCDEF0, 0, 1);

    // Plain reset after activity restores all outputs.
    op(4'he, 2'b11, 5'b11111, 1, 0, 4'd12, 4'd0, 32'hCAFE, 32'h0, 0, 0);
    @(negedge clk);
    reset = 1'b0; m_flags = 4'b0000; m_q = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst2_regwrite", RegWrite, 0);
    chk("rst2_wa3", WA3, 0);
    chk("rst2_wd3", WD3, 0);
    chk("rst2_flags", Flags, 0);
    chk("rst2_q", QFlag, 0);
    chk("rst2_ready", InReady, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
